// File: rtl/sbox_perm_ctrl.sv
// Builds a 256-entry byte permutation from a chaos stream, dropping duplicates and filling gaps after MAX_DRAWS.
// Latency: a table write appears 1 cycle after the accepted byte (or scanned fill value). Optional SBOX_PERM_INV_EN adds an inverse-table write port.
// Backpressure: in_ready is high only while collecting; bytes offered in any other state are not taken.
module sbox_perm_ctrl #(
  parameter int MAX_DRAWS = 4096,
  parameter int DRAW_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              tbl_we,
  output logic [7:0]        tbl_addr,
  output logic [7:0]        tbl_data,
  output logic              busy,
  output logic              done,
  output logic              fell_back,
  output logic [8:0]        count,
  output logic [DRAW_W-1:0] dup_cnt
`ifdef SBOX_PERM_INV_EN
  ,
  output logic              inv_we,
  output logic [7:0]        inv_addr,
  output logic [7:0]        inv_data
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_FILL, S_DONE} state_t;

  localparam logic [DRAW_W-1:0] LAST_DRAW = DRAW_W'(MAX_DRAWS - 1);

  state_t             state;
  logic [255:0]       bitmap;
  logic [DRAW_W-1:0]  draws;
  logic [7:0]         fill_ptr;

  logic hs;
  logic in_new;
  logic fill_new;

  assign hs       = in_valid & in_ready;
  assign in_new   = ~bitmap[in_data];
  assign fill_new = ~bitmap[fill_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      bitmap    <= '0;
      draws     <= '0;
      fill_ptr  <= '0;
      count     <= '0;
      dup_cnt   <= '0;
      in_ready  <= 1'b0;
      tbl_we    <= 1'b0;
      tbl_addr  <= '0;
      tbl_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fell_back <= 1'b0;
    end else begin
      tbl_we <= 1'b0;
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state     <= S_COLLECT;
            bitmap    <= '0;
            draws     <= '0;
            fill_ptr  <= '0;
            count     <= '0;
            dup_cnt   <= '0;
            fell_back <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b1;
            in_ready  <= 1'b1;
          end
        end
        S_COLLECT: begin
          if (hs) begin
            draws <= draws + DRAW_W'(1);
            if (in_new) begin
              bitmap[in_data] <= 1'b1;
              count           <= count + 9'd1;
              tbl_we          <= 1'b1;
              tbl_addr        <= count[7:0];
              tbl_data        <= in_data;
            end else if (dup_cnt != '1) begin
              dup_cnt <= dup_cnt + DRAW_W'(1);
            end
            // A table completed by this very byte wins over an exhausted draw budget.
            if (in_new && count == 9'd255) begin
              state    <= S_DONE;
              done     <= 1'b1;
              busy     <= 1'b0;
              in_ready <= 1'b0;
            end else if (draws == LAST_DRAW) begin
              state     <= S_FILL;
              fill_ptr  <= '0;
              fell_back <= 1'b1;
              in_ready  <= 1'b0;
            end
          end
        end
        S_FILL: begin
          if (fill_new) begin
            bitmap[fill_ptr] <= 1'b1;
            count            <= count + 9'd1;
            tbl_we           <= 1'b1;
            tbl_addr         <= count[7:0];
            tbl_data         <= fill_ptr;
          end
          // Exit lands no later than fill_ptr=255, so the pointer never wraps.
          if (fill_new && count == 9'd255) begin
            state <= S_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            fill_ptr <= fill_ptr + 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef SBOX_PERM_INV_EN
  assign inv_we   = tbl_we;
  assign inv_addr = tbl_data;
  assign inv_data = tbl_addr;
`endif

endmodule

// File: tb/tb_sbox_perm_ctrl.sv
// Randomised bench for sbox_perm_ctrl: a table-level reference model checked every cycle, plus literal pins.
module tb_sbox_perm_ctrl;
  localparam int MAXD = 300;
  localparam int DW   = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = '0;
  logic          in_ready, tbl_we, busy, done, fell_back;
  logic [7:0]    tbl_addr, tbl_data;
  logic [8:0]    count;
  logic [DW-1:0] dup_cnt;
`ifdef SBOX_PERM_INV_EN
  logic          inv_we;
  logic [7:0]    inv_addr, inv_data;
`endif

  always #5 clk = ~clk;

  sbox_perm_ctrl #(.MAX_DRAWS(MAXD), .DRAW_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .busy(busy), .done(done), .fell_back(fell_back), .count(count), .dup_cnt(dup_cnt)
`ifdef SBOX_PERM_INV_EN
    , .inv_we(inv_we), .inv_addr(inv_addr), .inv_data(inv_data)
`endif
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: phase 0=idle 1=collect 2=fill 3=done; table kept as an array.
  bit  seen [256];
  int  exp_tbl [256];
  int  m_phase, m_count, m_draws, m_dups, m_fell, m_ptr;
  bit  m_we;
  int  m_addr, m_data;

  task automatic model_reset();
    foreach (seen[i]) seen[i] = 1'b0;
    m_phase = 0; m_count = 0; m_draws = 0; m_dups = 0; m_fell = 0; m_ptr = 0;
    m_we = 1'b0; m_addr = 0; m_data = 0;
  endtask

  task automatic emit(input int v);
    seen[v] = 1'b1;
    exp_tbl[m_count] = v;
    m_we = 1'b1; m_addr = m_count; m_data = v;
    m_count++;
  endtask

  task automatic model_step();
    m_we = 1'b0;
    case (m_phase)
      0, 3: if (start) begin
        foreach (seen[i]) seen[i] = 1'b0;
        m_count = 0; m_draws = 0; m_dups = 0; m_fell = 0; m_ptr = 0;
        m_phase = 1;
      end
      1: if (in_valid) begin
        m_draws++;
        if (!seen[in_data]) emit(int'(in_data));
        else if (m_dups < 65535) m_dups++;
        if (m_count == 256) m_phase = 3;
        else if (m_draws == MAXD) begin m_phase = 2; m_ptr = 0; m_fell = 1; end
      end
      2: begin
        if (!seen[m_ptr]) emit(m_ptr);
        if (m_count == 256) m_phase = 3;
        else m_ptr++;
      end
      default: ;
    endcase
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // Captured DUT writes.
  logic [7:0] cap_tbl [256];
  logic [7:0] cap_inv [256];
  int wr_cnt = 0;

  initial begin
    forever begin
      @(negedge clk);
      check("in_ready", in_ready, m_phase == 1);
      check("busy", busy, m_phase == 1 || m_phase == 2);
      check("done", done, m_phase == 3);
      check("fell_back", fell_back, m_fell);
      check("count", count, m_count);
      check("dup_cnt", dup_cnt, m_dups);
      check("tbl_we", tbl_we, m_we);
      if (m_we) begin
        check("tbl_addr", tbl_addr, m_addr);
        check("tbl_data", tbl_data, m_data);
      end
      if (tbl_we) begin cap_tbl[tbl_addr] = tbl_data; wr_cnt++; end
`ifdef SBOX_PERM_INV_EN
      check("inv_we", inv_we, m_we);
      if (m_we) begin
        check("inv_addr", inv_addr, m_data);
        check("inv_data", inv_data, m_addr);
      end
      if (inv_we) cap_inv[inv_addr] = inv_data;
`endif
    end
  end

  task automatic do_start();
    foreach (cap_tbl[i]) begin cap_tbl[i] = '0; cap_inv[i] = '0; end
    wr_cnt = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] d);
    bit acc;
    int tries;
    tries = 0;
    in_valid = 1'b1;
    in_data  = d;
    do begin
      acc = in_ready;
      @(negedge clk);
      tries++;
    end while (!acc && tries < 20);
    check("send_accept", acc, 1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 2000) begin @(negedge clk); n++; end
    check("done_wait", done, 1);
  endtask

  task automatic check_perm();
    bit hit [256];
    int missing;
    missing = 0;
    foreach (hit[i]) hit[i] = 1'b0;
    foreach (cap_tbl[k]) hit[cap_tbl[k]] = 1'b1;
    foreach (hit[i]) if (!hit[i]) missing++;
    check("perm_missing", missing, 0);
    check("write_count", wr_cnt, 256);
    check("final_count", count, 256);
`ifdef SBOX_PERM_INV_EN
    begin
      int bad;
      bad = 0;
      foreach (cap_tbl[k]) if (int'(cap_inv[cap_tbl[k]]) != k) bad++;
      check("inv_mismatches", bad, 0);
    end
`endif
  endtask

  task automatic shuffle(output int p [256]);
    foreach (p[i]) p[i] = i;
    for (int i = 255; i > 0; i--) begin
      int j, t;
      j = int'($urandom_range(0, i));
      t = p[i]; p[i] = p[j]; p[j] = t;
    end
  endtask

  int perm [256];

  initial begin
    // Reset and idle with a byte offered.
    rst_n = 1'b0;
    in_valid = 1'b1;
    in_data = 8'h42;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_count", count, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_in_ready", in_ready, 0);
    check("idle_tbl_we", tbl_we, 0);
    check("idle_done", done, 0);
    check("idle_count", count, 0);
    idle(1);

    // Ideal stream 255..0 back-to-back.
    do_start();
    for (int k = 255; k >= 0; k--) send(8'(k));
    in_valid = 1'b0;
    check("ideal_done_next", done, 1);
    wait_done();
    check("ideal_dup", dup_cnt, 0);
    check("ideal_fell", fell_back, 0);
    begin
      int bad;
      bad = 0;
      for (int k = 0; k < 256; k++) if (exp_tbl[k] != 255 - k || int'(cap_tbl[k]) != 255 - k) bad++;
      check("ideal_table", bad, 0);
    end
    check_perm();
    idle(2);

    // Duplicate rejection, then random bytes until the draw budget forces a fill.
    do_start();
    send(8'h05); send(8'h05); send(8'h07); send(8'h05);
    idle(1);
    check("dup_count", count, 2);
    check("dup_dups", dup_cnt, 2);
    check("dup_e0", exp_tbl[0], 5);
    check("dup_e1", exp_tbl[1], 7);
    while (in_ready) send(8'($urandom));
    in_valid = 1'b0;
    wait_done();
    check_perm();
    idle(2);

    // Fallback: 0..9 then 290 copies of 3 exhaust MAX_DRAWS=300.
    do_start();
    for (int i = 0; i < 10; i++) send(8'(i));
    repeat (290) send(8'h03);
    in_valid = 1'b0;
    check("fb_fell_now", fell_back, 1);
    check("fb_in_ready", in_ready, 0);
    wait_done();
    check("fb_dups", dup_cnt, 290);
    check("fb_fell", fell_back, 1);
    begin
      int bad;
      bad = 0;
      for (int k = 0; k < 256; k++) if (exp_tbl[k] != k || int'(cap_tbl[k]) != k) bad++;
      check("fb_table", bad, 0);
    end
    check_perm();
    idle(2);

    // Random stalls over a shuffle, with an ignored start mid-run.
    shuffle(perm);
    do_start();
    for (int i = 0; i < 256; i++) begin
      int gap;
      gap = int'($urandom_range(0, 3));
      if (gap > 0) idle(gap);
      if (i == 50) start = 1'b1;
      send(8'(perm[i]));
      start = 1'b0;
    end
    in_valid = 1'b0;
    wait_done();
    check("stall_fell", fell_back, 0);
    check("stall_dups", dup_cnt, 0);
    begin
      int bad;
      bad = 0;
      for (int k = 0; k < 256; k++) if (int'(cap_tbl[k]) != perm[k]) bad++;
      check("stall_table", bad, 0);
    end
    check_perm();
    idle(2);

    // Reset mid-run, then a clean restart.
    shuffle(perm);
    do_start();
    for (int i = 0; i < 256 && wr_cnt < 100; i++) send(8'(perm[i]));
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_tbl_we", tbl_we, 0);
    check("mid_rst_count", count, 0);
    check("mid_rst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    shuffle(perm);
    do_start();
    for (int i = 0; i < 256; i++) send(8'(perm[i]));
    in_valid = 1'b0;
    wait_done();
    check_perm();
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sbox_perm_ctrl.md
Name: sbox_perm_ctrl

Overview:
- Sequencer that turns the chaotic byte stream into a 256-entry substitution/permutation table for the image cipher.
- Accepts chaos bytes through a valid/ready handshake and rejects duplicates using an internal 256-bit occupancy bitmap.
- Writes each first-occurrence byte to the table RAM at consecutive addresses.
- If the chaotic source stalls on duplicates past a draw budget, fills the remaining entries deterministically so the table is always a full permutation.

Parameters:
- MAX_DRAWS, 4096: accepted input bytes allowed in COLLECT before falling back to FILL. Range 256..65535.
- DRAW_W, 16: width of the draw counter. Must satisfy 2^DRAW_W > MAX_DRAWS.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins table generation.
- in_valid  in  1  chaos byte valid.
- in_data  in  8  chaos byte.
- in_ready  out  1  block accepts a byte this cycle.
- tbl_we  out  1  table write strobe.
- tbl_addr  out  8  table write address.
- tbl_data  out  8  table write data.
- busy  out  1  generation in progress.
- done  out  1  table complete; held until next start.
- fell_back  out  1  FILL state was used in the last run.
- count  out  9  entries written so far (0..256).
- dup_cnt  out  DRAW_W  duplicates rejected in the last run.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; bitmap, count, draws, dup_cnt, fill_ptr=0; all outputs 0.
- States: IDLE, COLLECT, FILL, DONE. Encoding is free.
- IDLE / DONE:
  - start -> COLLECT.
  - On the same edge: clear bitmap, count, draws, dup_cnt, fell_back, done.
- COLLECT:
  - in_ready=1 and busy=1.
  - Handshake is in_valid & in_ready. Each handshake increments draws.
  - bitmap[in_data]==0: set the bit, count+1. Next cycle tbl_we=1 for exactly one cycle, with tbl_addr=old count[7:0] and tbl_data=in_data. Write latency is 1 cycle.
  - bitmap[in_data]==1: no write; dup_cnt+1 (saturating).
  - Back-to-back unique bytes give one write per cycle with no bubbles.
  - Transition priority:
    - If count becomes 256 -> DONE.
    - Else if draws becomes MAX_DRAWS -> FILL with fill_ptr=0 and fell_back=1.
  - in_ready drops in the cycle after the final accepted byte.
- FILL:
  - in_ready=0. Scans fill_ptr 0..255, one value per cycle.
  - bitmap[fill_ptr]==0: set the bit, write fill_ptr at address count (same 1-cycle latency), count+1.
  - Values already present are skipped without a write.
  - Exit to DONE when count reaches 256. This is guaranteed at or before fill_ptr=255. fill_ptr never wraps.
- DONE:
  - done=1, busy=0, in_ready=0. count holds 256.
  - The last tbl_we may coincide with the first DONE cycle.
- start while busy is ignored. No abort input exists; rst_n is the only abort.
- Reset mid-run: outputs clear immediately and the table contents are undefined. The consumer must not use the table unless done=1.
- tbl_data over a completed run is always a permutation of 0..255.

Optional Feature:
- Macro: SBOX_PERM_INV_EN.
- With the macro defined, add these output ports:
  - inv_we  out  1
  - inv_addr  out  8
  - inv_data  out  8
- inv_we fires in the same cycle as every tbl_we, with inv_addr=tbl_data and inv_data=tbl_addr. This builds the decryption inverse table in parallel.
- Without the macro, these ports and their logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset/idle: hold rst_n low, then release; drive in_valid=1 -> in_ready=0, tbl_we=0, done=0, count=0.
- Ideal stream: start, then 256 distinct bytes 255..0 back-to-back -> 256 writes with addr k = data 255-k, one per cycle; done=1 one cycle after the last handshake; dup_cnt=0; fell_back=0.
- Duplicate rejection: feed 0x05,0x05,0x07,0x05 -> exactly 2 writes (addr0=0x05, addr1=0x07); dup_cnt=2; count=2.
- Fallback with MAX_DRAWS=300: feed 0x00..0x09 then 290 copies of 0x03 -> FILL writes 0x0A..0xFF to addresses 10..255 in ascending order; fell_back=1; done=1.
- Handshake stalls: random in_valid gaps of 0-3 cycles with a 256-value shuffle -> writes only on handshakes; table is a correct permutation.
- Reset mid-run and restart: assert rst_n after 100 writes -> outputs 0 at once; a new start and full run succeeds with count=256. With SBOX_PERM_INV_EN, check inv[tbl[k]]==k for all k.
